fifo_axis_drain: RTL and testbench
==================================

// Module: fifo_axis_drain
// PURPOSE
//  Read-side engine for the 512x32 user-area FIFO: pops a programmed number of words and
//  presents them as an AXI-Stream master with tlast on the final word.
//  Sits between the FIFO read port (rd_en / rd_data / empty) and downstream stream consumers
//  (FIR/matmul input, WB readback path).
//  Absorbs the FIFO's 1-cycle registered read latency and downstream backpressure without
//  dropping or duplicating words.
// PARAMETERS
//  DATA_W    32  stream and FIFO data width
//  LEN_W     10  width of cfg_len; frames of 0..1023 words
//  BUF_DEPTH 2   output buffer entries; must be >= 2 for 1 word/cycle throughput
// PORTS
//  clk            in   1       clock
//  reset          in   1       synchronous, active-high reset
//  vccd1/vssd1    inout 1      power pins, present only under USE_POWER_PINS
//  cfg_start      in   1       1-cycle pulse; begins a frame (ignored while busy)
//  cfg_len        in   LEN_W   frame length in words; sampled when cfg_start is accepted
//  busy           out  1       high from accepted start until done
//  done           out  1       1-cycle pulse at frame completion
//  fifo_rd_en     out  1       FIFO pop request
//  fifo_rd_data   in   DATA_W  FIFO data; valid the cycle after an accepted pop
//  fifo_empty     in   1       FIFO empty flag
//  m_axis_tvalid  out  1       stream valid
//  m_axis_tdata   out  DATA_W  stream data
//  m_axis_tlast   out  1       high with the last word of the frame
//  m_axis_tready  in   1       stream ready
// BEHAVIOUR
//  Reset:
//  - all outputs 0; state IDLE; counters 0; buffer empty; inflight flag 0.
//  FSM IDLE -> RUN -> FLUSH -> IDLE:
//  - IDLE: on cfg_start, latch len_q=cfg_len and clear issued/sent counters.
//    If cfg_len==0: no pops, done pulses the next cycle, busy stays 0. Otherwise go to RUN, busy=1.
//  - RUN: fifo_rd_en = ~fifo_empty & (issued<len_q) & (occ + inflight - out_fire < BUF_DEPTH),
//    where out_fire = tvalid & tready.
//    This is combinational from fifo_empty and tready, and rd_en is never high while fifo_empty.
//    An issued pop sets inflight and increments issued.
//    When issued==len_q, go to FLUSH.
//  - FLUSH: no pops; wait until sent==len_q.
//    Then assert done for 1 cycle, clear busy, and go to IDLE.
//  Data path:
//  - inflight word is written into the buffer tail in the cycle it appears on fifo_rd_data.
//  - tdata = buffer head; tvalid = occ!=0.
//  - first tvalid appears 2 cycles after the first rd_en cycle.
//  - throughput: 1 word/cycle when tready=1 and the FIFO is non-empty.
//  AXIS rules:
//  - once tvalid=1, tdata and tlast hold until tready=1.
//  - tlast = (sent==len_q-1) for the head word.
//  - sent increments on out_fire.
//  Simultaneous events:
//  - buffer push and pop in the same cycle keep occ unchanged.
//  - done asserts in the cycle after the final out_fire.
//  - cfg_start in the same cycle as done is ignored.
//  Reset mid-frame:
//  - everything is cleared next edge and tvalid drops immediately.
//  - words already popped from the FIFO are discarded.
//  Widths: issued and sent are LEN_W bits and never wrap, since they are bounded by len_q.
// STRUCTURE
//  - Shared include wlos_defs.vh: DATA_W default, FSM state encodings (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2).
//  - One sub-module, axis_out_buf: BUF_DEPTH-entry circular buffer with push/pop/occ/head.
//  - Top module holds the FSM, the counters and the rd_en credit logic.
// TESTING
//  1. FIFO preloaded 1,2,3,4; len=4; tready=1
//     -> rd_en 4 consecutive cycles; tdata 1,2,3,4 on consecutive cycles; tlast only on 4;
//     done 1 cycle after the 4th fire.
//  2. len=8, FIFO full of 10..17; tready=0 for 6 cycles then 1
//     -> at most 2 pops during the stall; output 10..17 in order, no gaps or duplicates.
//  3. len=3, FIFO empty for 5 cycles then written 7,8,9
//     -> rd_en stays 0 while empty; output 7,8,9 with tlast on 9.
//  4. cfg_len=0 -> no rd_en, tvalid never asserted, done pulse next cycle, busy stays 0.
//  5. reset asserted after 2 of 5 words sent
//     -> next cycle all outputs 0, state IDLE; a new start with len=2 completes normally.
//  6. cfg_start pulsed while busy -> ignored; the frame length stays the original len_q.

Source files
------------

// File: rtl/fifo_axis_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_axis_drain_pkg
//  Description : Shared types and defaults for the FIFO-to-AXI-Stream drain
//                engine: FSM state encoding and buffer sizing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_axis_drain_pkg;

    localparam int C_DATA_W_DEFAULT    = 32;
    localparam int C_LEN_W_DEFAULT     = 10;
    localparam int C_BUF_DEPTH_DEFAULT = 2;

    // Frame sequencing states; encodings are fixed so they match other users.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Width needed to count 0..depth buffer entries.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_axis_drain_out_buf.sv
`default_nettype none
// ============================================================================
//  Module      : axis_out_buf
//  Description : Small circular output buffer. Push and pop may occur in the
//                same cycle; the head entry is always presented on head_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_out_buf
    import fifo_axis_drain_pkg::*;
#(
    parameter int DATA_W = C_DATA_W_DEFAULT,
    parameter int DEPTH  = C_BUF_DEPTH_DEFAULT,
    parameter int OCC_W  = occ_width(C_BUF_DEPTH_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [OCC_W-1:0]  occ_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; simultaneous push+pop leaves occ unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule
`default_nettype wire

// File: rtl/fifo_axis_drain.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_axis_drain
//  Description : Pops a programmed number of words from a registered-read
//                FIFO and streams them out as an AXI-Stream master, with
//                tlast on the final word. Credit logic keeps at most
//                BUF_DEPTH words buffered or in flight, so backpressure never
//                drops or duplicates data.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_axis_drain
    import fifo_axis_drain_pkg::*;
#(
    parameter int DATA_W    = C_DATA_W_DEFAULT,
    parameter int LEN_W     = C_LEN_W_DEFAULT,
    parameter int BUF_DEPTH = C_BUF_DEPTH_DEFAULT
) (
`ifdef USE_POWER_PINS
    inout  wire               vccd1,
    inout  wire               vssd1,
`endif
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              busy,
    output logic              done,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
);

    localparam int OCC_W = occ_width(BUF_DEPTH);

    state_t            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q;
    logic [LEN_W-1:0]  issued_d;
    logic [LEN_W-1:0]  sent_q;
    logic [LEN_W-1:0]  sent_d;
    logic              busy_q;
    logic              done_q;
    logic              inflight_q;

    logic [OCC_W-1:0]  occ;
    logic [DATA_W-1:0] head;
    logic [OCC_W:0]    credit;
    logic              out_fire;
    logic              rd_en;

    // Pop credit: buffered words plus the one in flight, less the one leaving now.
    always_comb begin
        out_fire = m_axis_tvalid & m_axis_tready;
        credit   = (OCC_W+1)'(occ) + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(out_fire);
        rd_en    = ~reset & (state_q == ST_RUN) & ~fifo_empty &
                   (issued_q < len_q) & (credit < (OCC_W+1)'(BUF_DEPTH));
        issued_d = issued_q + LEN_W'(rd_en);
        sent_d   = sent_q + LEN_W'(out_fire);
    end

    // Frame sequencer: counters, busy/done and the pop-in-flight marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= rd_en;
            case (state_q)
                ST_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (cfg_start && !done_q) begin
                        len_q    <= cfg_len;
                        issued_q <= '0;
                        sent_q   <= '0;
                        if (cfg_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    issued_q <= issued_d;
                    sent_q   <= sent_d;
                    if (issued_d == len_q) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    sent_q <= sent_d;
                    if (sent_d == len_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The word popped last cycle is on fifo_rd_data now and goes to the tail.
    axis_out_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH),
        .OCC_W  (OCC_W)
    ) u_out_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (fifo_rd_data),
        .pop_i       (out_fire),
        .head_o      (head),
        .occ_o       (occ)
    );

    // Stream outputs are masked while reset is high so tvalid drops at once.
    assign m_axis_tvalid = ~reset & (occ != '0);
    assign m_axis_tdata  = m_axis_tvalid ? head : '0;
    assign m_axis_tlast  = m_axis_tvalid & (sent_q == len_q - LEN_W'(1));
    assign fifo_rd_en    = rd_en;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_axis_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_axis_drain
//  Description : Directed self-checking bench for fifo_axis_drain with a
//                behavioural registered-read FIFO and an expected-word queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_axis_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic [9:0]  cfg_len;
    logic        busy;
    logic        done;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = '0;
    logic        fifo_empty = 1'b1;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    // FIFO model controls
    logic        wr_en;
    logic [31:0] wr_data;
    logic        fifo_clr;
    logic [31:0] fifo_q [$];

    // Scoreboard: {tlast, tdata}
    logic [32:0] exp_q [$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int start_cyc, n_rd, first_rd, last_rd, n_fire, first_fire, last_fire;
    int first_tv, done_cnt, done_cyc;
    int rd_empty_cnt = 0;
    int hold_err = 0;
    bit tvalid_seen, busy_seen, hold_pend;
    logic [31:0] hold_d;
    logic        hold_l;

    always #5 clk = ~clk;

    fifo_axis_drain dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_start     (cfg_start),
        .cfg_len       (cfg_len),
        .busy          (busy),
        .done          (done),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_empty    (fifo_empty),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    // Registered-read FIFO with registered empty flag.
    always @(posedge clk) begin
        if (fifo_clr) begin
            fifo_q.delete();
        end else begin
            if (fifo_rd_en && !fifo_empty) fifo_rd_data <= fifo_q.pop_front();
            if (wr_en) fifo_q.push_back(wr_data);
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_stats();
        n_rd = 0; first_rd = -1; last_rd = -1;
        n_fire = 0; first_fire = -1; last_fire = -1;
        first_tv = -1; done_cnt = 0; done_cyc = -1;
        tvalid_seen = 0; busy_seen = 0;
    endtask

    // One clock: sample at the falling edge, return just after the rising edge.
    task automatic tick();
        logic [32:0] e;
        @(negedge clk);
        cyc++;
        if (fifo_rd_en) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (fifo_empty) rd_empty_cnt++;
        end
        if (m_axis_tvalid && !tvalid_seen) first_tv = cyc;
        if (m_axis_tvalid) tvalid_seen = 1;
        if (busy) busy_seen = 1;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (hold_pend && !reset &&
            (!m_axis_tvalid || m_axis_tdata !== hold_d || m_axis_tlast !== hold_l))
            hold_err++;
        hold_pend = m_axis_tvalid && !m_axis_tready && !reset;
        hold_d = m_axis_tdata;
        hold_l = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
            n_fire++;
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
            if (exp_q.size() == 0) begin
                chk("extra_word", m_axis_tdata, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                chk("tdata", m_axis_tdata, e[31:0]);
                chk("tlast", {31'd0, m_axis_tlast}, {31'd0, e[32]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr_words(input int base, input int n, input bit to_exp);
        logic l;
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            wr_data = 32'(base + i);
            l = (i == n - 1);
            if (to_exp) exp_q.push_back({l, wr_data});
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic start(input logic [9:0] len);
        cfg_start = 1'b1;
        cfg_len = len;
        tick();
        start_cyc = cyc;
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            tick();
            k++;
        end
        chk("done_timeout", {31'd0, (done_cnt != 0)}, 32'd1);
    endtask

    task automatic flush_fifo();
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_len = '0; m_axis_tready = 1'b1;
        wr_en = 1'b0; wr_data = '0; fifo_clr = 1'b0;
        clear_stats();
        @(posedge clk); #1;
        tick();
        chk("reset_outputs", {26'd0, busy, done, fifo_rd_en, m_axis_tvalid, m_axis_tlast, 1'b0}, 32'd0);
        chk("reset_tdata", m_axis_tdata, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_outputs", {27'd0, busy, done, fifo_rd_en, m_axis_tvalid, m_axis_tlast}, 32'd0);

        // 1: four preloaded words, no backpressure
        wr_words(1, 4, 1);
        tick();
        clear_stats();
        start(10'd4);
        wait_done(40);
        tick(); tick();
        chk("t1_rd_count", 32'(n_rd), 32'd4);
        chk("t1_rd_consec", 32'(last_rd - first_rd), 32'd3);
        chk("t1_first_valid", 32'(first_tv), 32'(first_rd + 2));
        chk("t1_fire_count", 32'(n_fire), 32'd4);
        chk("t1_fire_consec", 32'(last_fire - first_fire), 32'd3);
        chk("t1_done_cycle", 32'(done_cyc), 32'(last_fire + 1));
        chk("t1_done_pulses", 32'(done_cnt), 32'd1);
        chk("t1_busy_after", {31'd0, busy}, 32'd0);

        // 2: eight words, 6-cycle stall at the start
        wr_words(10, 8, 1);
        tick();
        clear_stats();
        m_axis_tready = 1'b0;
        start(10'd8);
        for (int i = 0; i < 6; i++) tick();
        chk("t2_stall_pops", 32'(n_rd), 32'd2);
        chk("t2_stall_valid", {31'd0, m_axis_tvalid}, 32'd1);
        m_axis_tready = 1'b1;
        wait_done(60);
        chk("t2_fire_count", 32'(n_fire), 32'd8);
        chk("t2_no_gaps", 32'(last_fire - first_fire), 32'd7);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // 3: FIFO starts empty, words arrive later
        clear_stats();
        start(10'd3);
        for (int i = 0; i < 5; i++) tick();
        chk("t3_no_rd_empty", 32'(n_rd), 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        wr_words(7, 3, 1);
        wait_done(40);
        chk("t3_fire_count", 32'(n_fire), 32'd3);

        // 4: zero-length frame; start held into the done cycle must be ignored
        wr_words(99, 1, 0);
        tick();
        clear_stats();
        cfg_start = 1'b1; cfg_len = 10'd0;
        tick();
        start_cyc = cyc;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t4_done_cycle", 32'(done_cyc), 32'(start_cyc + 1));
        chk("t4_done_pulses", 32'(done_cnt), 32'd1);
        chk("t4_no_rd", 32'(n_rd), 32'd0);
        chk("t4_no_valid", {31'd0, tvalid_seen}, 32'd0);
        chk("t4_no_busy", {31'd0, busy_seen}, 32'd0);
        flush_fifo();

        // 5: reset after two words sent, then a fresh two-word frame
        wr_words(20, 5, 1);
        tick();
        clear_stats();
        start(10'd5);
        for (int k = 0; k < 20 && n_fire < 2; k++) tick();
        chk("t5_two_sent", 32'(n_fire), 32'd2);
        m_axis_tready = 1'b0;
        reset = 1'b1;
        tick();
        chk("t5_valid_drop", {31'd0, m_axis_tvalid}, 32'd0);
        reset = 1'b0;
        tick();
        chk("t5_outputs_clear", {27'd0, busy, done, fifo_rd_en, m_axis_tvalid, m_axis_tlast}, 32'd0);
        chk("t5_tdata_clear", m_axis_tdata, 32'd0);
        flush_fifo();
        exp_q.delete();
        m_axis_tready = 1'b1;
        wr_words(30, 2, 1);
        tick();
        clear_stats();
        start(10'd2);
        wait_done(40);
        chk("t5_new_fires", 32'(n_fire), 32'd2);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // 6: start pulse while busy does not change the frame length
        wr_words(40, 3, 1);
        wr_words(43, 4, 0);
        tick();
        clear_stats();
        start(10'd3);
        tick();
        cfg_start = 1'b1; cfg_len = 10'd7;
        tick();
        cfg_start = 1'b0;
        wait_done(40);
        tick(); tick(); tick();
        chk("t6_rd_count", 32'(n_rd), 32'd3);
        chk("t6_fire_count", 32'(n_fire), 32'd3);
        chk("t6_done_pulses", 32'(done_cnt), 32'd1);
        chk("t6_busy_after", {31'd0, busy}, 32'd0);
        flush_fifo();

        chk("rd_when_empty", 32'(rd_empty_cnt), 32'd0);
        chk("hold_stable", 32'(hold_err), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
